// File: rtl/jogo_pkg.sv
// Shared definitions for the battleship game sequencer: state codes,
// switch decodes and status LED colours ({R,G,B}).
package jogo_pkg;

  typedef enum logic [2:0] {
    DESLIGADO  = 3'd0,
    PREPARACAO = 3'd1,
    PRONTO     = 3'd2,
    ATAQUE     = 3'd3,
    ESPERA     = 3'd4,
    DERROTA    = 3'd5,
    VITORIA    = 3'd6
  } estado_t;

  localparam logic [1:0] MODO_DESLIGADO = 2'b00;
  localparam logic [1:0] MODO_PREP      = 2'b01;

  typedef logic [2:0] cor_t;
  localparam cor_t COR_OFF      = 3'b000;
  localparam cor_t COR_VERMELHO = 3'b100;
  localparam cor_t COR_VERDE    = 3'b010;
  localparam cor_t COR_AZUL     = 3'b001;

  localparam logic [5:0] MAX_CELULAS = 6'd35;

endpackage

// File: rtl/controlador_jogo_if.sv
// Signal bundle between the game sequencer and its surrounding blocks.
interface controlador_jogo_if;
  logic [1:0] modo;
  logic       confirmar;
  logic [5:0] celulas_navio;
  logic       resp_valida;
  logic       resp_acerto;
  logic       resp_repetido;
  logic       habilita_selecao;
  logic       carregar_mapa;
  logic       req_ataque;
  logic       habilita_matriz;
  logic [1:0] vida;
  logic [5:0] acertos;
  logic [2:0] estado;
  logic       erro_timeout;
  logic       LED_R;
  logic       LED_G;
  logic       LED_B;

  modport master (
    output modo, confirmar, celulas_navio, resp_valida, resp_acerto, resp_repetido,
    input  habilita_selecao, carregar_mapa, req_ataque, habilita_matriz,
           vida, acertos, estado, erro_timeout, LED_R, LED_G, LED_B
  );

  modport slave (
    input  modo, confirmar, celulas_navio, resp_valida, resp_acerto, resp_repetido,
    output habilita_selecao, carregar_mapa, req_ataque, habilita_matriz,
           vida, acertos, estado, erro_timeout, LED_R, LED_G, LED_B
  );
endinterface

// File: rtl/temporizador_led.sv
// Status colour register with a load/countdown hold; "fixo" pins a colour
// indefinitely (end-of-game displays).
module temporizador_led
  import jogo_pkg::*;
#(
  parameter int HOLD = 8
) (
  input  logic clock_in,
  input  logic rst_n,
  input  logic limpar,
  input  logic fixo,
  input  logic carregar,
  input  cor_t cor_in,
  output cor_t cor
);
  localparam int CW = $clog2(HOLD + 1);

  logic [CW-1:0] cnt;

  // cnt counts the remaining extra cycles, so the colour is visible HOLD cycles
  always_ff @(posedge clock_in or negedge rst_n) begin
    if (!rst_n) begin
      cor <= COR_OFF;
      cnt <= '0;
    end else if (limpar) begin
      cor <= COR_OFF;
      cnt <= '0;
    end else if (fixo) begin
      cor <= cor_in;
      cnt <= '0;
    end else if (carregar) begin
      cor <= cor_in;
      cnt <= CW'(HOLD - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end else begin
      cor <= COR_OFF;
    end
  end
endmodule

// File: rtl/controlador_jogo.sv
// Battleship game sequencer: mode decode, map lock, one attack request per
// press, response wait with timeout, hit/miss tally and end-of-game decision.
module controlador_jogo
  import jogo_pkg::*;
#(
  parameter int NUM_VIDAS    = 3,
  parameter int TIMEOUT_RESP = 4,
  parameter int LED_HOLD     = 8
) (
  input logic clock_in,
  input logic rst_n,
  controlador_jogo_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_RESP + 1);

  estado_t       state, nxt;
  logic [TW-1:0] wait_cnt;
  logic [5:0]    celulas_lat, acertos, acertos_inc;
  logic [1:0]    vida, vida_inc;
  logic          carregar_mapa, req_ataque, erro_timeout;
  logic          hab_sel, hab_mat;
  logic          desligar, resp_ok;
  logic          ev_carga, ev_req, ev_timeout, ev_acerto, ev_erro, ev_rep;
  logic          tmr_fixo, tmr_load;
  cor_t          tmr_cor, cor;

  assign acertos_inc = (acertos == MAX_CELULAS) ? acertos : acertos + 6'd1;
  assign vida_inc    = (vida == 2'(NUM_VIDAS)) ? vida : vida + 2'd1;

  always_ff @(posedge clock_in or negedge rst_n) begin
    if (!rst_n) state <= DESLIGADO;
    else        state <= nxt;
  end

  always_comb begin
    nxt        = state;
    ev_carga   = 1'b0;
    ev_req     = 1'b0;
    ev_timeout = 1'b0;
    ev_acerto  = 1'b0;
    ev_erro    = 1'b0;
    ev_rep     = 1'b0;
    desligar   = (bus.modo == MODO_DESLIGADO);
    // the request cycle itself is already ESPERA; responses there are too early
    resp_ok    = (state == ESPERA) && !req_ataque && bus.resp_valida;
    if (desligar) begin
      nxt = DESLIGADO;
    end else begin
      case (state)
        DESLIGADO:  if (bus.modo == MODO_PREP) nxt = PREPARACAO;
        PREPARACAO: if (bus.confirmar && bus.celulas_navio != 6'd0) begin
                      ev_carga = 1'b1;
                      nxt      = PRONTO;
                    end
        PRONTO:     if (bus.modo[1]) nxt = ATAQUE;
        ATAQUE:     if (bus.confirmar) begin
                      ev_req = 1'b1;
                      nxt    = ESPERA;
                    end
        ESPERA: begin
          if (resp_ok) begin
            if (bus.resp_repetido) begin
              ev_rep = 1'b1;
              nxt    = ATAQUE;
            end else if (bus.resp_acerto) begin
              ev_acerto = 1'b1;
              nxt       = (acertos_inc == celulas_lat) ? VITORIA : ATAQUE;
            end else begin
              ev_erro = 1'b1;
              nxt     = (vida_inc == 2'(NUM_VIDAS)) ? DERROTA : ATAQUE;
            end
          end else if (wait_cnt == TW'(TIMEOUT_RESP)) begin
            ev_timeout = 1'b1;
            nxt        = ATAQUE;
          end
        end
        default: nxt = state;
      endcase
    end
  end

  always_ff @(posedge clock_in or negedge rst_n) begin
    if (!rst_n) begin
      carregar_mapa <= 1'b0;
      req_ataque    <= 1'b0;
      erro_timeout  <= 1'b0;
      hab_sel       <= 1'b0;
      hab_mat       <= 1'b0;
      wait_cnt      <= '0;
      celulas_lat   <= '0;
      acertos       <= '0;
      vida          <= '0;
    end else begin
      carregar_mapa <= ev_carga;
      req_ataque    <= ev_req;
      erro_timeout  <= ev_timeout;
      hab_sel       <= (nxt == PREPARACAO);
      hab_mat       <= nxt inside {PREPARACAO, PRONTO, ATAQUE, ESPERA, VITORIA};
      if (ev_req)
        wait_cnt <= '0;
      else if (state == ESPERA && wait_cnt != TW'(TIMEOUT_RESP))
        wait_cnt <= wait_cnt + 1'b1;
      if (desligar) begin
        celulas_lat <= '0;
        acertos     <= '0;
        vida        <= '0;
      end else begin
        if (ev_carga)  celulas_lat <= bus.celulas_navio;
        if (ev_acerto) acertos     <= acertos_inc;
        if (ev_erro)   vida        <= vida_inc;
      end
    end
  end

  assign tmr_fixo = (nxt == VITORIA) || (nxt == DERROTA);
  assign tmr_load = ev_rep || ev_acerto || ev_erro;
  assign tmr_cor  = (nxt == VITORIA) ? COR_VERDE    :
                    (nxt == DERROTA) ? COR_VERMELHO :
                    ev_rep           ? COR_AZUL     :
                    ev_acerto        ? COR_VERDE    : COR_VERMELHO;

  temporizador_led #(.HOLD(LED_HOLD)) u_led (
    .clock_in (clock_in),
    .rst_n    (rst_n),
    .limpar   (desligar),
    .fixo     (tmr_fixo),
    .carregar (tmr_load),
    .cor_in   (tmr_cor),
    .cor      (cor)
  );

  assign bus.estado           = state;
  assign bus.carregar_mapa    = carregar_mapa;
  assign bus.req_ataque       = req_ataque;
  assign bus.erro_timeout     = erro_timeout;
  assign bus.habilita_selecao = hab_sel;
  assign bus.habilita_matriz  = hab_mat;
  assign bus.vida             = vida;
  assign bus.acertos          = acertos;
  assign {bus.LED_R, bus.LED_G, bus.LED_B} = cor;
endmodule

// File: doc/controlador_jogo.md
# controlador_jogo

Registered game sequencer for the battleship board game. Decodes the mode switches, gates map selection and attack confirmation, issues one attack request per button press to the attack datapath, and tallies hits and misses. It decides victory or defeat and drives the status LEDs and the LED-matrix enable. It sits between the debounced inputs (switches, `level_to_pulse` output) and the map selector, attack datapath, matrix and display blocks.

## Interface
Parameters:
- `NUM_VIDAS`, 3: misses allowed before defeat (1..3; `vida` saturates at this value)
- `TIMEOUT_RESP`, 4: cycles to wait for `resp_valida` after `req_ataque`
- `LED_HOLD`, 8: cycles a per-shot status colour is held

Ports:
- `clock_in`  in  1  system clock (divided clock domain of the game logic)
- `rst_n`  in  1  asynchronous, active-low reset
- `modo`  in  2  {ch7,ch6}: 00 off, 01 preparation, 1x attack
- `confirmar`  in  1  single-cycle pulse from the debounced button
- `celulas_navio`  in  6  count of ship cells in the currently selected map (0..35)
- `resp_valida`  in  1  attack datapath result strobe
- `resp_acerto`  in  1  shot hit a ship cell (valid with `resp_valida`)
- `resp_repetido`  in  1  cell already attacked (valid with `resp_valida`; overrides `resp_acerto`)
- `habilita_selecao`  out  1  map selector enable
- `carregar_mapa`  out  1  one-cycle pulse: latch the selected map
- `req_ataque`  out  1  one-cycle pulse: evaluate the current coordinates
- `habilita_matriz`  out  1  LED matrix enable
- `vida`  out  2  misses so far
- `acertos`  out  6  distinct hits so far
- `estado`  out  3  state code for the display
- `erro_timeout`  out  1  one-cycle pulse on response timeout
- `LED_R`, `LED_G`, `LED_B`  out  1 each  status LEDs, active-high

## Operation
- States and codes: DESLIGADO 0, PREPARACAO 1, PRONTO 2, ATAQUE 3, ESPERA 4, DERROTA 5, VITORIA 6.
- `modo`==00 in any state: go to DESLIGADO; clear `vida`, `acertos`, the latched cell count and the LED timer.
- DESLIGADO:
  - `modo`==01 goes to PREPARACAO.
  - `modo`==1x stays. Attack without a map is refused.
- PREPARACAO (`habilita_selecao`=1):
  - `confirmar` with `celulas_navio`!=0: pulse `carregar_mapa`, latch `celulas_navio`, go to PRONTO.
  - `confirmar` with `celulas_navio`==0: ignored.
- PRONTO:
  - `modo`==1x goes to ATAQUE.
  - `confirmar` is ignored; the map stays locked.
- ATAQUE: `confirmar` pulses `req_ataque`, clears the wait counter and goes to ESPERA.
- ESPERA, on `resp_valida`:
  - repeated cell: no count change, blue hold, go to ATAQUE.
  - hit: `acertos`+1, green hold. Go to VITORIA if the new count equals the latched cell count, else ATAQUE.
  - miss: `vida`+1, red hold. Go to DERROTA if the new count equals `NUM_VIDAS`, else ATAQUE.
- ESPERA timeout: after `TIMEOUT_RESP` cycles with no `resp_valida`, pulse `erro_timeout` and go to ATAQUE with no count change.
- DERROTA and VITORIA: held until `modo`==00.
- `modo`==01 while in PRONTO..VITORIA: ignored. Only a switch to off restarts the game.
- `confirmar` outside PREPARACAO and ATAQUE: ignored. `resp_valida` outside ESPERA: ignored.
- `habilita_matriz`=1 in PREPARACAO, PRONTO, ATAQUE, ESPERA and VITORIA; 0 in DESLIGADO and DERROTA.
- LEDs:
  - VITORIA: solid green. DERROTA: solid red.
  - Otherwise the held shot colour for `LED_HOLD` cycles, then all off.
  - A new result restarts the hold.
- Counters saturate: `vida` at `NUM_VIDAS`, `acertos` at 35.

## Timing
- All outputs are registered.
- Reset values: state DESLIGADO; all outputs 0 (`estado`=0).
- `carregar_mapa` and `req_ataque` are asserted in the cycle after the `confirmar` pulse, for exactly one cycle.
- `resp_valida` is accepted from the cycle after `req_ataque` onward.
- `resp_valida` in the same cycle as `req_ataque` is ignored.
- `resp_valida` on the cycle the counter reaches `TIMEOUT_RESP`: the response wins and there is no timeout.
- Count updates, the state change and the LED colour appear together, one cycle after `resp_valida`.
- `modo`==00 coincident with any event: off wins.
- `rst_n` low mid-ESPERA: immediate return to the reset values. No `req_ataque` is reissued after release.

## Structure
- Shared package `jogo_pkg`: state encoding, mode codes (`MODO_DESLIGADO`=00, `MODO_PREP`=01), LED colour constants, maximum cell count 35.
- Sub-module `temporizador_led`: a load/countdown hold timer with a colour register, instantiated once.
- FSM, counters and timeout live in `controlador_jogo`.

## Test plan
- Reset, then `modo`=1x → stays DESLIGADO; `estado`=0, `habilita_matriz`=0.
- `modo`=01, `confirmar` with `celulas_navio`=0 → stays PREPARACAO. Retry with 3 → one-cycle `carregar_mapa`, `estado`=2.
- Attack with 3 cells, responses hit, repeated, hit, hit → `acertos`=3, `vida`=0, VITORIA, solid green; repeated shot gives a blue hold with no count change.
- `NUM_VIDAS`=3, three misses → `vida`=3, DERROTA, `LED_R`=1, `habilita_matriz`=0.
- `req_ataque` with no response for 4 cycles → `erro_timeout` pulse, back to ATAQUE, counts unchanged. Response on cycle 4 → counted, no timeout.
- `modo`=00 in ESPERA coincident with `resp_valida`=1 → DESLIGADO, counts 0. `rst_n` pulse mid-game → all outputs 0.
